vram_cpu_port: RTL and testbench
================================

Name: vram_cpu_port

Overview:
- CPU-side initiator for the VDP's synchronous video RAM.
- Implements the classic two-port host interface:
  - data port: read/write VRAM through an auto-incrementing address with a read-ahead buffer.
  - control port: two-byte sequence that sets the address or writes a VDP register.
- Performs RAM accesses only in cycles the display fetcher marks free; drives the RAM address/data/write-enable and captures read data one cycle later.

Parameters:
- A, 14, VRAM address width in bits.
- D, 8, data width in bits; the control-port byte format requires D=8.
- R, 3, VDP register-select width in bits.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cpu_wr  input  1  single-cycle host write strobe
- cpu_rd  input  1  single-cycle host read strobe
- cpu_mode  input  1  0 = data port, 1 = control port
- cpu_din  input  D  host write data
- cpu_dout  output  D  read-ahead buffer contents
- busy  output  1  a VRAM operation is pending
- slot_free  input  1  display fetch does not use RAM this cycle
- ram_req  output  1  this block owns the RAM this cycle; arbiter selects its address/data
- ram_addr  output  A  VRAM address (current address register)
- ram_din  output  D  data to RAM
- ram_we  output  1  RAM write enable
- ram_dout  input  D  RAM read data, valid one clk after the address is presented
- reg_we  output  1  one-cycle VDP register write pulse
- reg_sel  output  R  register number
- reg_val  output  D  register value

Behaviour:
- Reset values:
  - State IDLE; addr, buffer, latch byte, ram_din, reg_sel and reg_val all 0.
  - Control toggle = first byte.
  - busy, ram_req, ram_we and reg_we all 0.
  - Reset mid-operation abandons any pending access; no RAM write occurs in the reset cycle.
- Registers: addr[A-1:0], buf[D-1:0] (drives cpu_dout), lat[D-1:0], toggle, wdata[D-1:0].
- Control port write (cpu_mode=1):
  - toggle=0: lat <= cpu_din; toggle <= 1.
  - toggle=1, cpu_din[7:6]:
    - 00: addr <= {cpu_din[5:0], lat} truncated to A bits; enter RD_WAIT (prefetch).
    - 01: same address load; stay IDLE (write setup).
    - 10: reg_we pulses next cycle with reg_sel = cpu_din[R-1:0] and reg_val = lat.
    - 11: ignored.
  - In all toggle=1 cases, toggle <= 0.
- Data port write: toggle <= 0; wdata <= cpu_din; buf <= cpu_din; enter WR_WAIT.
- Data port read: toggle <= 0; cpu_dout already holds buf; enter RD_WAIT (prefetch next byte).
- States: IDLE, RD_WAIT, RD_CAP, WR_WAIT.
  - WR_WAIT & slot_free: ram_req=1, ram_we=1, ram_din=wdata (combinational this cycle); addr <= addr+1; then IDLE. Without slot_free, hold indefinitely.
  - RD_WAIT & slot_free: ram_req=1, ram_we=0; go to RD_CAP.
  - RD_CAP: buf <= ram_dout; addr <= addr+1; then IDLE. ram_req=0, RAM not required.
- busy = (state != IDLE).
- Best-case latency:
  - Write commits 1 cycle after the strobe.
  - Read buffer updates 2 cycles after the strobe, visible on the 3rd.
- Address wraps from 2^A-1 to 0; bits above A are discarded.
- Host strobes (either port) while busy are dropped entirely: no state, toggle or buffer change.
- cpu_wr and cpu_rd together: cpu_wr wins, cpu_rd is ignored.
- A reg write does not assert busy and does not touch addr.

Optional Feature:
- Macro VRAM_CPU_OVERRUN_EN.
- Defined:
  - Adds ports overrun (output 1) and overrun_clr (input 1).
  - overrun is a sticky flag, set the cycle after any strobe is dropped while busy.
  - Cleared by reset or overrun_clr; if set and clear coincide, set wins.
- Undefined: ports absent; drops remain silent.

Test Plan:
- Register write: reset; control writes 0x34 then 0x85 -> one reg_we pulse with reg_sel=5, reg_val=0x34; addr unchanged; busy stays 0.
- Write setup and burst: control 0x00, 0x41; data writes 0xAA, 0xBB with slot_free=1 -> RAM[0x0100]=0xAA, RAM[0x0101]=0xBB; each ram_we exactly 1 cycle; final addr=0x0102.
- Read prefetch: preload RAM[0x0200]=0x11, RAM[0x0201]=0x22; control 0x00, 0x02 -> cpu_dout=0x11 after 3 cycles. A data read then leaves cpu_dout=0x22, addr=0x0202.
- Slot blocking: slot_free=0 for 10 cycles after a data write -> busy high, ram_we low throughout; write commits in the first cycle slot_free=1.
- Wrap and drop: addr=0x3FFF, data write 0x5A -> RAM[0x3FFF]=0x5A, addr=0x0000. A second write strobed while busy is not committed (overrun=1 when VRAM_CPU_OVERRUN_EN is defined).
- Reset mid-operation: data write with slot_free=0, assert reset, then slot_free=1 -> no RAM write; all outputs at reset values; toggle is first-byte.

Source files
------------

// File: rtl/vram_cpu_port.sv
// vram_cpu_port: host-side initiator for the VDP video RAM.
// Data port: auto-incrementing address with a one-byte read-ahead buffer.
// Control port: two-byte sequence for address load or VDP register write.
// RAM accesses are issued only in cycles the display fetcher leaves free.
// Optional macro VRAM_CPU_OVERRUN_EN adds a sticky flag (overrun/overrun_clr)
// for host strobes dropped while an access is pending.
module vram_cpu_port #(
  parameter int A = 14,
  parameter int D = 8,
  parameter int R = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_wr,
  input  logic         cpu_rd,
  input  logic         cpu_mode,
  input  logic [D-1:0] cpu_din,
  output logic [D-1:0] cpu_dout,
  output logic         busy,
  input  logic         slot_free,
  output logic         ram_req,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_din,
  output logic         ram_we,
  input  logic [D-1:0] ram_dout,
  output logic         reg_we,
  output logic [R-1:0] reg_sel,
  output logic [D-1:0] reg_val
`ifdef VRAM_CPU_OVERRUN_EN
  ,
  output logic         overrun,
  input  logic         overrun_clr
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAP, WR_WAIT} state_t;

  state_t       state_reg, state_next;
  logic [A-1:0] addr_reg;
  logic [D-1:0] buf_reg;
  logic [D-1:0] lat_reg;
  logic [D-1:0] wdata_reg;
  logic         toggle_reg;
  logic         reg_we_reg;
  logic [R-1:0] reg_sel_reg;
  logic [D-1:0] reg_val_reg;

  // Strobes are only honoured while idle; a write beats a simultaneous read.
  logic         accept;
  logic         data_wr, data_rd, ctl_first, ctl_second;
  logic [1:0]   cmd;
  logic         addr_load;
  logic         addr_inc;
  logic [13:0]  load_full;

  assign accept     = (state_reg == IDLE);
  assign data_wr    = accept & cpu_wr & ~cpu_mode;
  assign data_rd    = accept & ~cpu_wr & cpu_rd & ~cpu_mode;
  assign ctl_first  = accept & cpu_wr & cpu_mode & ~toggle_reg;
  assign ctl_second = accept & cpu_wr & cpu_mode & toggle_reg;
  assign cmd        = cpu_din[7:6];
  assign addr_load  = ctl_second & ~cmd[1];
  assign load_full  = {cpu_din[5:0], lat_reg};
  assign addr_inc   = ((state_reg == WR_WAIT) & slot_free) | (state_reg == RD_CAP);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: strobes start accesses, free slots advance them.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (data_wr)                        state_next = WR_WAIT;
        else if (data_rd)                   state_next = RD_WAIT;
        else if (ctl_second && cmd == 2'b00) state_next = RD_WAIT;
      end
      WR_WAIT: if (slot_free) state_next = IDLE;
      RD_WAIT: if (slot_free) state_next = RD_CAP;
      RD_CAP:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: RAM ownership is claimed only in a free slot, never in reset.
  always_comb begin
    ram_req = 1'b0;
    ram_we  = 1'b0;
    ram_din = '0;
    busy    = (state_reg != IDLE);
    case (state_reg)
      WR_WAIT: begin
        ram_din = wdata_reg;
        if (slot_free && !reset) begin
          ram_req = 1'b1;
          ram_we  = 1'b1;
        end
      end
      RD_WAIT: if (slot_free && !reset) ram_req = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: address, read-ahead buffer, control latch and register port.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg    <= '0;
      buf_reg     <= '0;
      lat_reg     <= '0;
      wdata_reg   <= '0;
      toggle_reg  <= 1'b0;
      reg_we_reg  <= 1'b0;
      reg_sel_reg <= '0;
      reg_val_reg <= '0;
    end else begin
      reg_we_reg <= 1'b0;
      if (addr_load)     addr_reg <= A'(load_full);
      else if (addr_inc) addr_reg <= addr_reg + A'(1);
      if (data_wr) begin
        wdata_reg <= cpu_din;
        buf_reg   <= cpu_din;
      end else if (state_reg == RD_CAP) begin
        buf_reg <= ram_dout;
      end
      if (ctl_first) begin
        lat_reg    <= cpu_din;
        toggle_reg <= 1'b1;
      end else if (ctl_second || data_wr || data_rd) begin
        toggle_reg <= 1'b0;
      end
      if (ctl_second && cmd == 2'b10) begin
        reg_we_reg  <= 1'b1;
        reg_sel_reg <= cpu_din[R-1:0];
        reg_val_reg <= lat_reg;
      end
    end
  end

`ifdef VRAM_CPU_OVERRUN_EN
  logic overrun_reg;

  // Sticky drop flag; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)                                overrun_reg <= 1'b0;
    else if ((cpu_wr || cpu_rd) && !accept)   overrun_reg <= 1'b1;
    else if (overrun_clr)                     overrun_reg <= 1'b0;
  end

  assign overrun = overrun_reg;
`endif

  assign cpu_dout = buf_reg;
  assign ram_addr = addr_reg;
  assign reg_we   = reg_we_reg;
  assign reg_sel  = reg_sel_reg;
  assign reg_val  = reg_val_reg;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed testbench for vram_cpu_port with a registered-read VRAM model.
module tb_vram_cpu_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_wr = 1'b0, cpu_rd = 1'b0, cpu_mode = 1'b0;
  logic [7:0]  cpu_din = 8'h00;
  logic [7:0]  cpu_dout;
  logic        busy;
  logic        slot_free = 1'b1;
  logic        ram_req;
  logic [13:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout = 8'h00;
  logic        reg_we;
  logic [2:0]  reg_sel;
  logic [7:0]  reg_val;
`ifdef VRAM_CPU_OVERRUN_EN
  logic        overrun;
  logic        overrun_clr = 1'b0;
`endif

  int tests_run = 0;
  int fails = 0;
  int we_count = 0;
  int reg_count = 0;
  logic [7:0] mem [0:16383];

  vram_cpu_port #(.A(14), .D(8), .R(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_mode(cpu_mode),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
    .slot_free(slot_free), .ram_req(ram_req), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .reg_we(reg_we), .reg_sel(reg_sel), .reg_val(reg_val)
`ifdef VRAM_CPU_OVERRUN_EN
    , .overrun(overrun), .overrun_clr(overrun_clr)
`endif
  );

  always #5 clk = ~clk;

  // VRAM model: write when owned, read data one clock after the address
  always @(posedge clk) begin
    if (ram_req && ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
    if (ram_req && ram_we) we_count <= we_count + 1;
    if (reg_we) reg_count <= reg_count + 1;
  end

  // One-cycle host strobe; returns at the negedge after the sampling edge
  task automatic strobe(input logic wr, input logic rd, input logic mode, input logic [7:0] v);
    @(negedge clk);
    cpu_wr = wr; cpu_rd = rd; cpu_mode = mode; cpu_din = v;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    $display("[TB] strobe wr=%0b rd=%0b mode=%0b din=0x%02h busy=%0b addr=0x%04h", wr, rd, mode, v, busy, ram_addr);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (busy) begin
      fails++;
      $display("FAIL wait_idle: busy=%0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, ram_req, ram_we, reg_we} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: busy/req/we/reg_we=%b required 0000", {busy, ram_req, ram_we, reg_we});
    end
    tests_run++;
    if ({ram_addr, cpu_dout, ram_din} !== 30'h0) begin
      fails++;
      $display("FAIL reset_regs: addr=0x%04h dout=0x%02h din=0x%02h required 0", ram_addr, cpu_dout, ram_din);
    end
  endtask

  task automatic test_reg_write();
    int rc;
    rc = reg_count;
    strobe(1, 0, 1, 8'h34);
    strobe(1, 0, 1, 8'h85);
    tests_run++;
    if ({reg_we, reg_sel, reg_val} !== {1'b1, 3'd5, 8'h34}) begin
      fails++;
      $display("FAIL reg_write: we=%0b sel=%0d val=0x%02h required 1 5 0x34", reg_we, reg_sel, reg_val);
    end
    tests_run++;
    if (busy !== 1'b0 || ram_addr !== 14'h0000) begin
      fails++;
      $display("FAIL reg_write_side: busy=%0b addr=0x%04h required 0 0x0000", busy, ram_addr);
    end
    @(negedge clk);
    tests_run++;
    if (reg_we !== 1'b0 || reg_count - rc != 1) begin
      fails++;
      $display("FAIL reg_pulse: reg_we=%0b pulses=%0d required 0 and 1 pulse", reg_we, reg_count - rc);
    end
  endtask

  task automatic test_write_burst();
    int wc;
    slot_free = 1'b1;
    strobe(1, 0, 1, 8'h00);
    strobe(1, 0, 1, 8'h41);
    tests_run++;
    if (ram_addr !== 14'h0100 || busy !== 1'b0) begin
      fails++;
      $display("FAIL write_setup: addr=0x%04h busy=%0b required 0x0100 0", ram_addr, busy);
    end
    wc = we_count;
    strobe(1, 0, 0, 8'hAA);
    tests_run++;
    if (ram_we !== 1'b1 || ram_din !== 8'hAA) begin
      fails++;
      $display("FAIL write_latency: ram_we=%0b din=0x%02h required 1 0xaa", ram_we, ram_din);
    end
    wait_idle();
    strobe(1, 0, 0, 8'hBB);
    wait_idle();
    tests_run++;
    if (mem[14'h0100] !== 8'hAA || mem[14'h0101] !== 8'hBB) begin
      fails++;
      $display("FAIL write_burst: mem100=0x%02h mem101=0x%02h required 0xaa 0xbb", mem[14'h0100], mem[14'h0101]);
    end
    tests_run++;
    if (we_count - wc != 2 || ram_addr !== 14'h0102) begin
      fails++;
      $display("FAIL write_count: we_cycles=%0d addr=0x%04h required 2 0x0102", we_count - wc, ram_addr);
    end
  endtask

  task automatic test_read_prefetch();
    @(negedge clk);
    mem[14'h0200] = 8'h11;
    mem[14'h0201] = 8'h22;
    strobe(1, 0, 1, 8'h00);
    strobe(1, 0, 1, 8'h02);
    tests_run++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL prefetch_busy: busy=%0b required 1", busy);
    end
    @(negedge clk);
    tests_run++;
    if (cpu_dout !== 8'hBB) begin
      fails++;
      $display("FAIL prefetch_early: dout=0x%02h required 0xbb", cpu_dout);
    end
    @(negedge clk);
    tests_run++;
    if (cpu_dout !== 8'h11 || busy !== 1'b0 || ram_addr !== 14'h0201) begin
      fails++;
      $display("FAIL prefetch: dout=0x%02h busy=%0b addr=0x%04h required 0x11 0 0x0201", cpu_dout, busy, ram_addr);
    end
    strobe(0, 1, 0, 8'h00);
    wait_idle();
    tests_run++;
    if (cpu_dout !== 8'h22 || ram_addr !== 14'h0202) begin
      fails++;
      $display("FAIL data_read: dout=0x%02h addr=0x%04h required 0x22 0x0202", cpu_dout, ram_addr);
    end
  endtask

  task automatic test_slot_block();
    int bad;
    bad = 0;
    @(negedge clk);
    slot_free = 1'b0;
    strobe(1, 0, 0, 8'h77);
    repeat (10) begin
      if (busy !== 1'b1 || ram_we !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0 || mem[14'h0202] !== 8'h00) begin
      fails++;
      $display("FAIL slot_hold: bad_cycles=%0d mem202=0x%02h required 0 0x00", bad, mem[14'h0202]);
    end
    slot_free = 1'b1;
    #1;
    tests_run++;
    if (ram_we !== 1'b1 || ram_req !== 1'b1) begin
      fails++;
      $display("FAIL slot_grant: ram_we=%0b ram_req=%0b required 1 1", ram_we, ram_req);
    end
    @(negedge clk);
    tests_run++;
    if (mem[14'h0202] !== 8'h77 || busy !== 1'b0 || ram_addr !== 14'h0203) begin
      fails++;
      $display("FAIL slot_commit: mem202=0x%02h busy=%0b addr=0x%04h required 0x77 0 0x0203", mem[14'h0202], busy, ram_addr);
    end
  endtask

  task automatic test_wrap_drop();
    int wc;
    strobe(1, 0, 1, 8'hFF);
    strobe(1, 0, 1, 8'h7F);
    tests_run++;
    if (ram_addr !== 14'h3FFF) begin
      fails++;
      $display("FAIL wrap_setup: addr=0x%04h required 0x3fff", ram_addr);
    end
    wc = we_count;
    @(negedge clk);
    slot_free = 1'b0;
    strobe(1, 0, 0, 8'h5A);
    strobe(1, 0, 0, 8'h66);
    slot_free = 1'b1;
    wait_idle();
    @(negedge clk);
    tests_run++;
    if (mem[14'h3FFF] !== 8'h5A || ram_addr !== 14'h0000) begin
      fails++;
      $display("FAIL wrap: mem3fff=0x%02h addr=0x%04h required 0x5a 0x0000", mem[14'h3FFF], ram_addr);
    end
    tests_run++;
    if (we_count - wc != 1 || mem[14'h0000] !== 8'h00 || cpu_dout !== 8'h5A) begin
      fails++;
      $display("FAIL drop: we_cycles=%0d mem0=0x%02h dout=0x%02h required 1 0x00 0x5a", we_count - wc, mem[14'h0000], cpu_dout);
    end
`ifdef VRAM_CPU_OVERRUN_EN
    tests_run++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: overrun=%0b required 1", overrun);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clr: overrun=%0b required 0", overrun);
    end
`endif
  endtask

  task automatic test_wr_rd_priority();
    strobe(1, 1, 0, 8'h3C);
    wait_idle();
    tests_run++;
    if (mem[14'h0000] !== 8'h3C || ram_addr !== 14'h0001) begin
      fails++;
      $display("FAIL wr_rd_priority: mem0=0x%02h addr=0x%04h required 0x3c 0x0001", mem[14'h0000], ram_addr);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    slot_free = 1'b0;
    strobe(1, 0, 0, 8'hE1);
    reset = 1'b1;
    slot_free = 1'b1;
    #1;
    tests_run++;
    if (ram_we !== 1'b0 || ram_req !== 1'b0) begin
      fails++;
      $display("FAIL reset_cycle: ram_we=%0b ram_req=%0b required 0 0", ram_we, ram_req);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if ({busy, ram_req, ram_we, reg_we} !== 4'b0000 || {ram_addr, cpu_dout, ram_din, reg_sel, reg_val} !== 41'h0) begin
      fails++;
      $display("FAIL reset_mid: busy=%0b req=%0b we=%0b reg_we=%0b addr=0x%04h dout=0x%02h din=0x%02h sel=%0d val=0x%02h required all 0",
               busy, ram_req, ram_we, reg_we, ram_addr, cpu_dout, ram_din, reg_sel, reg_val);
    end
    @(negedge clk);
    tests_run++;
    if (mem[14'h0001] !== 8'h00) begin
      fails++;
      $display("FAIL reset_abandon: mem1=0x%02h required 0x00", mem[14'h0001]);
    end
    strobe(1, 0, 1, 8'h99);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    strobe(1, 0, 1, 8'h56);
    strobe(1, 0, 1, 8'h83);
    tests_run++;
    if ({reg_we, reg_sel, reg_val} !== {1'b1, 3'd3, 8'h56}) begin
      fails++;
      $display("FAIL reset_toggle: we=%0b sel=%0d val=0x%02h required 1 3 0x56", reg_we, reg_sel, reg_val);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    test_reset();
    test_reg_write();
    test_write_burst();
    test_read_prefetch();
    test_slot_block();
    test_wrap_drop();
    test_wr_rd_priority();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
